// File: rtl/addsub_digit_serial_if.sv
// Handshake and operand/result bundle for the digit-serial adder/subtractor.
// The master drives the request side; the slave (the datapath) returns result and flags.
interface addsub_digit_serial_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             carry_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;
  logic             zero;

  modport master (
    output start, sub, in1, in2, carry_in,
    input  busy, done, sum, carry_out, overflow, zero
  );

  modport slave (
    input  start, sub, in1, in2, carry_in,
    output busy, done, sum, carry_out, overflow, zero
  );
endinterface

// File: rtl/addsub_digit_serial.sv
// Multi-cycle adder/subtractor: one DIGIT-wide ripple chain is reused NUM_DIGITS times,
// with the inter-digit carry held in a register; result and flags update only on completion.
module addsub_digit_serial #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  addsub_digit_serial_if.slave  bus
);

  localparam int NUM_DIGITS = WIDTH / DIGIT;
  localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("addsub_digit_serial: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Returns {carry_out, sum} of a DIGIT-bit ripple full-adder chain.
  function automatic logic [DIGIT:0] digit_add(
    input logic [DIGIT-1:0] a,
    input logic [DIGIT-1:0] b,
    input logic             c
  );
    logic [DIGIT:0]   carry;
    logic [DIGIT-1:0] s;
    carry[0] = c;
    for (int i = 0; i < DIGIT; i++) begin
      s[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
    return {carry[DIGIT], s};
  endfunction

  state_t           state_r, state_s;
  logic [WIDTH-1:0] a_r, b_r, part_r;
  logic             carry_r;
  logic [IDX_W-1:0] idx_r;
  logic             busy_r, done_r, carry_out_r, overflow_r, zero_r;
  logic [WIDTH-1:0] sum_r;

  logic             accept_s, last_s;
  logic [31:0]      lo_s;
  logic [DIGIT:0]   add_s;
  logic [WIDTH-1:0] next_part_s;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode: accept when idle, return to idle after the last digit.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    last_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          accept_s = 1'b1;
          state_s  = ST_BUSY;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (idx_r == LAST_IDX) begin
          last_s  = 1'b1;
          state_s = ST_IDLE;
        end else begin
          state_s = ST_BUSY;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Digit adder: slice the current digit and merge its sum into the partial result.
  always_comb begin
    lo_s        = 32'(idx_r) * 32'(DIGIT);
    add_s       = digit_add(a_r[lo_s +: DIGIT], b_r[lo_s +: DIGIT], carry_r);
    next_part_s = part_r;
    next_part_s[lo_s +: DIGIT] = add_s[DIGIT-1:0];
  end

  // Operand latch, per-digit accumulation and completion-time result/flag update.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      part_r      <= {WIDTH{1'b0}};
      carry_r     <= 1'b0;
      idx_r       <= {IDX_W{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      sum_r       <= {WIDTH{1'b0}};
      carry_out_r <= 1'b0;
      overflow_r  <= 1'b0;
      zero_r      <= 1'b0;
    end else begin
      busy_r <= (state_s == ST_BUSY);
      done_r <= last_s;
      if (accept_s) begin
        a_r     <= bus.in1;
        b_r     <= bus.sub ? ~bus.in2 : bus.in2;
        carry_r <= bus.sub ? 1'b1 : bus.carry_in;
        idx_r   <= {IDX_W{1'b0}};
      end else if (state_r == ST_BUSY) begin
        part_r  <= next_part_s;
        carry_r <= add_s[DIGIT];
        idx_r   <= idx_r + 1'b1;
        if (last_s) begin
          sum_r       <= next_part_s;
          carry_out_r <= add_s[DIGIT];
          overflow_r  <= (a_r[WIDTH-1] == b_r[WIDTH-1]) &&
                         (next_part_s[WIDTH-1] != a_r[WIDTH-1]);
          zero_r      <= (next_part_s == {WIDTH{1'b0}});
        end
      end
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.sum       = sum_r;
  assign bus.carry_out = carry_out_r;
  assign bus.overflow  = overflow_r;
  assign bus.zero      = zero_r;

endmodule

// File: tb/tb_addsub_digit_serial.sv
// Directed bench for addsub_digit_serial: default 8/2 build plus 8/1, 8/8 and 12/4 builds.
module tb_addsub_digit_serial;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_failed;

  addsub_digit_serial_if #(.WIDTH(8))  m_if ();
  addsub_digit_serial_if #(.WIDTH(8))  s1_if ();
  addsub_digit_serial_if #(.WIDTH(8))  s8_if ();
  addsub_digit_serial_if #(.WIDTH(12)) s12_if ();

  addsub_digit_serial #(.WIDTH(8),  .DIGIT(2)) u_dut   (.clk(clk), .rst(rst), .bus(m_if.slave));
  addsub_digit_serial #(.WIDTH(8),  .DIGIT(1)) u_dut1  (.clk(clk), .rst(rst), .bus(s1_if.slave));
  addsub_digit_serial #(.WIDTH(8),  .DIGIT(8)) u_dut8  (.clk(clk), .rst(rst), .bus(s8_if.slave));
  addsub_digit_serial #(.WIDTH(12), .DIGIT(4)) u_dut12 (.clk(clk), .rst(rst), .bus(s12_if.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation on the 8/2 build from the current cycle and check result, flags and timing.
  task automatic run_op(input string tag, input logic s, input logic [7:0] a, input logic [7:0] b,
                        input logic ci, input logic [7:0] es, input logic eco, input logic eov,
                        input logic ez);
    int cyc;
    int bc;
    m_if.start = 1'b1; m_if.sub = s; m_if.in1 = a; m_if.in2 = b; m_if.carry_in = ci;
    step();
    m_if.start = 1'b0; m_if.in1 = 8'hA5; m_if.in2 = 8'h5A; m_if.sub = ~s; m_if.carry_in = ~ci;
    cyc = 0;
    bc  = 0;
    while (!m_if.done && cyc < 20) begin
      if (m_if.busy) bc++;
      step();
      cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'd4);
    check({tag, "_busy_cycles"}, 32'(bc), 32'd4);
    check({tag, "_done"}, 32'(m_if.done), 32'd1);
    check({tag, "_busy_at_done"}, 32'(m_if.busy), 32'd0);
    check({tag, "_sum"}, 32'(m_if.sum), 32'(es));
    check({tag, "_flags"}, {29'd0, m_if.carry_out, m_if.overflow, m_if.zero}, {29'd0, eco, eov, ez});
  endtask

  initial begin
    int cyc;
    int seen;
    int d1, d8, d12;
    n_tests  = 0;
    n_failed = 0;
    m_if.start = 1'b0;   m_if.sub = 1'b0;   m_if.in1 = 8'h00;   m_if.in2 = 8'h00;   m_if.carry_in = 1'b0;
    s1_if.start = 1'b0;  s1_if.sub = 1'b0;  s1_if.in1 = 8'h00;  s1_if.in2 = 8'h00;  s1_if.carry_in = 1'b0;
    s8_if.start = 1'b0;  s8_if.sub = 1'b0;  s8_if.in1 = 8'h00;  s8_if.in2 = 8'h00;  s8_if.carry_in = 1'b0;
    s12_if.start = 1'b0; s12_if.sub = 1'b0; s12_if.in1 = 12'h000; s12_if.in2 = 12'h000; s12_if.carry_in = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_outputs", {19'd0, m_if.busy, m_if.done, m_if.carry_out, m_if.overflow, m_if.zero, m_if.sum},
          32'd0);

    run_op("add_5a_33",  1'b0, 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1, 1'b0);
    run_op("add_ff_01",  1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    run_op("add_cin",    1'b0, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
    run_op("sub_10_20",  1'b1, 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b0);
    run_op("sub_80_01",  1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1, 1'b0);

    // start during busy must be ignored
    step();
    m_if.start = 1'b1; m_if.sub = 1'b0; m_if.in1 = 8'h01; m_if.in2 = 8'h02; m_if.carry_in = 1'b0;
    step();
    m_if.start = 1'b0;
    step();
    m_if.start = 1'b1; m_if.in1 = 8'h40; m_if.in2 = 8'h40;
    step();
    m_if.start = 1'b0;
    cyc = 2;
    while (!m_if.done && cyc < 20) begin
      step();
      cyc++;
    end
    check("ignore_latency", 32'(cyc), 32'd4);
    check("ignore_sum", 32'(m_if.sum), 32'h03);
    run_op("back_to_back", 1'b0, 8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
    step();
    check("done_one_cycle", 32'(m_if.done), 32'd0);
    check("sum_holds", 32'(m_if.sum), 32'h80);

    // reset in busy cycle 2 aborts the operation
    m_if.start = 1'b1; m_if.in1 = 8'h5A; m_if.in2 = 8'h33;
    step();
    m_if.start = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_outputs", {19'd0, m_if.busy, m_if.done, m_if.carry_out, m_if.overflow, m_if.zero, m_if.sum},
          32'd0);
    seen = 0;
    repeat (8) begin
      step();
      if (m_if.done) seen = 1;
    end
    check("midrst_no_done", 32'(seen), 32'd0);
    run_op("after_rst", 1'b0, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);

    // reset and start on the same edge: start is dropped
    rst = 1'b1; m_if.start = 1'b1; m_if.in1 = 8'h11; m_if.in2 = 8'h22;
    step();
    rst = 1'b0; m_if.start = 1'b0;
    check("rst_start_busy", 32'(m_if.busy), 32'd0);
    seen = 0;
    repeat (6) begin
      step();
      if (m_if.done || m_if.busy) seen = 1;
    end
    check("rst_start_dropped", 32'(seen), 32'd0);

    // parameter sweep, all three builds started on the same edge
    s1_if.start = 1'b1;  s1_if.in1 = 8'h7F;    s1_if.in2 = 8'h00;    s1_if.carry_in = 1'b1;
    s8_if.start = 1'b1;  s8_if.in1 = 8'h7F;    s8_if.in2 = 8'h00;    s8_if.carry_in = 1'b1;
    s12_if.start = 1'b1; s12_if.in1 = 12'hFFF; s12_if.in2 = 12'h001; s12_if.carry_in = 1'b0;
    step();
    s1_if.start = 1'b0; s8_if.start = 1'b0; s12_if.start = 1'b0;
    d1 = -1; d8 = -1; d12 = -1;
    for (int c = 0; c <= 12; c++) begin
      if (s1_if.done && d1 < 0) d1 = c;
      if (s8_if.done && d8 < 0) d8 = c;
      if (s12_if.done && d12 < 0) d12 = c;
      step();
    end
    check("d1_latency", 32'(d1), 32'd8);
    check("d1_sum", 32'(s1_if.sum), 32'h80);
    check("d1_flags", {29'd0, s1_if.carry_out, s1_if.overflow, s1_if.zero}, 32'b010);
    check("d8_latency", 32'(d8), 32'd1);
    check("d8_sum", 32'(s8_if.sum), 32'h80);
    check("d8_flags", {29'd0, s8_if.carry_out, s8_if.overflow, s8_if.zero}, 32'b010);
    check("w12_latency", 32'(d12), 32'd3);
    check("w12_sum", 32'(s12_if.sum), 32'h000);
    check("w12_flags", {29'd0, s12_if.carry_out, s12_if.overflow, s12_if.zero}, 32'b101);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
